pip_reg_elastic: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers.
- A single elastic pipeline stage with valid/ready handshake, a 2-entry skid buffer, synchronous flush, and bubble masking of control fields.
- Sits between any two core stages (F/D, D/E, E/M, M/W). The hazard unit drives the stall via ready_i and the squash via flush_i, without per-stage custom logic.
- Payload is split into a data field (passed as-is) and a control field (forced to zero whenever the output is not valid).

---
 rtl/pip_reg_elastic.sv | 160 ++++++++++++++++
 tb/tb_pip_reg_elastic.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pip_reg_elastic.sv
// rtl/pip_reg_elastic.sv - elastic pipeline stage with 2-entry skid buffer, flush and bubble masking
//
// Purpose: one valid/ready pipeline register placed between two core stages.
//   A main entry drives the outputs. A skid entry catches the beat that was
//   already in flight when the downstream stage stalled. Control bits are
//   forced to zero whenever the output holds no valid beat.
// Optional feature: define PIP_REG_PERF_CNT_EN to add the stall and bubble counters.
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   valid_i, data_i,
//   ctrl_i, ready_o        upstream beat and this stage's accept indication
//   flush_i                synchronous squash of every held entry
//   valid_o, data_o,
//   ctrl_o, ready_i        downstream beat and downstream accept (low = stall)
//   stall_cnt_o,
//   bubble_cnt_o           performance counters (PIP_REG_PERF_CNT_EN only)
module pip_reg_elastic #(
    parameter int DATA_WIDTH = 96,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o
`ifdef PIP_REG_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  bubble_cnt_o
`endif
);

    // State bits are {skid valid, main valid}; 2'b10 cannot be reached.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_HALF  = 2'b01,
        S_FULL  = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_data_q, skid_data_q;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, skid_ctrl_q;

    logic accept, drain;
    logic load_main_in, load_main_skid, load_skid;

    // ready_o comes straight from a state bit, so ready_i never reaches it.
    assign ready_o = ~state_q[1];
    assign valid_o = state_q[0];
    assign data_o  = main_data_q;
    assign ctrl_o  = state_q[0] ? main_ctrl_q : '0;

    assign accept = valid_i & ready_o;
    assign drain  = valid_o & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            // Squash wins over a simultaneous accept: the incoming beat is dropped.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = S_HALF;
                    end
                end
                S_HALF: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = S_FULL;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // ready_o is low here, so no new beat can arrive.
                    if (drain) begin
                        load_main_skid = 1'b1;
                        state_d        = S_HALF;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Data is only captured on an accepted beat, so an X on data_i while
    // valid_i is low never gets into the entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush_i) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (load_main_in) begin
                main_data_q <= data_i;
                main_ctrl_q <= ctrl_i;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
                skid_ctrl_q <= '0;
            end
            if (load_skid) begin
                skid_data_q <= data_i;
                skid_ctrl_q <= ctrl_i;
            end
        end
    end

`ifdef PIP_REG_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] stall_cnt_q, bubble_cnt_q;

    // Free-running counters that wrap; flush does not clear them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (valid_o && !ready_i) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (!valid_o && ready_i) begin
                bubble_cnt_q <= bubble_cnt_q + CntOne;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pip_reg_elastic.sv
// tb/tb_pip_reg_elastic.sv - self-checking bench for pip_reg_elastic against a 2-deep FIFO model
module tb_pip_reg_elastic;

    localparam int DW = 96;
    localparam int CW = 8;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          valid_i, ready_o, flush_i, valid_o, ready_i;
    logic [DW-1:0] data_i, data_o;
    logic [CW-1:0] ctrl_i, ctrl_o;
`ifdef PIP_REG_PERF_CNT_EN
    logic [NW-1:0] stall_cnt_o, bubble_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t   q[$];
    longint  m_stall  = 0;
    longint  m_bubble = 0;

    always #5 clk = ~clk;

    pip_reg_elastic #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .ctrl_i  (ctrl_i),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .ctrl_o  (ctrl_o)
`ifdef PIP_REG_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    // Reference: the stage behaves as an in-order FIFO of depth 2.
    function automatic logic exp_valid();
        return q.size() > 0;
    endfunction
    function automatic logic exp_ready();
        return q.size() < 2;
    endfunction
    function automatic logic [CW-1:0] exp_ctrl();
        return (q.size() > 0) ? q[0].c : '0;
    endfunction
    function automatic logic [DW-1:0] exp_data();
        return (q.size() > 0) ? q[0].d : '0;
    endfunction
    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, settle.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r, input logic f);
        bit acc, drn;
        valid_i = v; data_i = d; ctrl_i = c; ready_i = r; flush_i = f;
        @(posedge clk);
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && r;
        if (q.size() > 0 && !r) m_stall++;
        if (q.size() == 0 && r) m_bubble++;
        if (f) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back({d, c});
        end
        #1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        rst_ni = 1'b0; valid_i = 1'b1; data_i = 96'hABC; ctrl_i = 8'h55;
        ready_i = 1'b1; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", ready_o); end
        checks++; if (ctrl_o !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", ctrl_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
        rst_ni = 1'b1;
        q.delete(); m_stall = 0; m_bubble = 0;
        d = rnd_data();
        drive(1'b1, d, 8'h5A, 1'b1, 1'b0);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL first_valid got %0b exp 1", valid_o); end
        checks++; if (ctrl_o !== 8'h5A) begin errors++; $display("FAIL first_ctrl got %h exp 5a", ctrl_o); end
        checks++; if (data_o !== d) begin errors++; $display("FAIL first_data got %h exp %h", data_o, d); end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, rnd_data(), i[CW-1:0], 1'b1, 1'b0);
            checks++; if (ctrl_o !== i[CW-1:0]) begin errors++; $display("FAIL stream_ctrl got %h exp %h", ctrl_o, i[CW-1:0]); end
            checks++; if (data_o !== exp_data()) begin errors++; $display("FAIL stream_data got %h exp %h", data_o, exp_data()); end
            checks++; if (valid_o !== 1'b1 || ready_o !== 1'b1) begin
                errors++; $display("FAIL stream_hs got valid=%0b ready=%0b exp 1/1", valid_o, ready_o);
            end
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %0b exp 0", valid_o); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] da, db, dc;
        da = rnd_data(); db = rnd_data(); dc = rnd_data();
        drive(1'b1, da, 8'h11, 1'b0, 1'b0);
        drive(1'b1, db, 8'h22, 1'b0, 1'b0);
        checks++; if (ctrl_o !== 8'h11 || data_o !== da) begin errors++; $display("FAIL bp_hold_a got %h exp 11", ctrl_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %0b exp 0", ready_o); end
        drive(1'b1, dc, 8'h33, 1'b0, 1'b0);
        checks++; if (ctrl_o !== 8'h11 || ready_o !== 1'b0) begin
            errors++; $display("FAIL bp_stall got ctrl=%h ready=%0b exp 11/0", ctrl_o, ready_o);
        end
        drive(1'b1, dc, 8'h33, 1'b1, 1'b0);
        checks++; if (ctrl_o !== 8'h22 || data_o !== db) begin errors++; $display("FAIL bp_out_b got %h exp 22", ctrl_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b exp 1", ready_o); end
        drive(1'b1, dc, 8'h33, 1'b1, 1'b0);
        checks++; if (ctrl_o !== 8'h33 || data_o !== dc) begin errors++; $display("FAIL bp_out_c got %h exp 33", ctrl_o); end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++; if (valid_o !== 1'b0 || ctrl_o !== 8'h00) begin
            errors++; $display("FAIL bp_drained got valid=%0b ctrl=%h exp 0/00", valid_o, ctrl_o);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, rnd_data(), 8'h41, 1'b0, 1'b0);
        drive(1'b1, rnd_data(), 8'h42, 1'b0, 1'b0);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_full got ready=%0b exp 0", ready_o); end
        drive(1'b1, rnd_data(), 8'h7F, 1'b0, 1'b1);
        checks++; if (valid_o !== 1'b0 || ctrl_o !== 8'h00 || ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_clear got valid=%0b ctrl=%h ready=%0b exp 0/00/1", valid_o, ctrl_o, ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            checks++; if (valid_o !== 1'b0 || ctrl_o === 8'h7F) begin
                errors++; $display("FAIL flush_dropped got valid=%0b ctrl=%h exp 0/00", valid_o, ctrl_o);
            end
        end
    endtask

    task automatic test_bubble();
        drive(1'b1, rnd_data(), 8'hC3, 1'b1, 1'b0);
        checks++; if (ctrl_o !== 8'hC3) begin errors++; $display("FAIL bubble_beat got %h exp c3", ctrl_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, rnd_data(), 8'hFF, 1'b1, 1'b0);
            checks++; if (ctrl_o !== 8'h00 || valid_o !== 1'b0) begin
                errors++; $display("FAIL bubble_mask got ctrl=%h valid=%0b exp 00/0", ctrl_o, valid_o);
            end
        end
        drive(1'b1, rnd_data(), 8'h3C, 1'b1, 1'b0);
        checks++; if (ctrl_o !== 8'h3C) begin errors++; $display("FAIL bubble_next got %h exp 3c", ctrl_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), rnd_data(), $urandom_range(0, 255),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
            checks++; if (valid_o !== exp_valid() || ready_o !== exp_ready() || ctrl_o !== exp_ctrl()) begin
                errors++; $display("FAIL rand_out cyc %0d got v=%0b r=%0b c=%h exp v=%0b r=%0b c=%h",
                                   i, valid_o, ready_o, ctrl_o, exp_valid(), exp_ready(), exp_ctrl());
            end
            if (exp_valid()) begin
                checks++; if (data_o !== exp_data()) begin
                    errors++; $display("FAIL rand_data cyc %0d got %h exp %h", i, data_o, exp_data());
                end
            end
        end
    endtask

`ifdef PIP_REG_PERF_CNT_EN
    task automatic test_perf_cnt();
        drive(1'b1, rnd_data(), 8'h01, 1'b1, 1'b0);
        repeat (5) drive(1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++; if (stall_cnt_o !== m_stall[NW-1:0]) begin
            errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt_o, m_stall[NW-1:0]);
        end
        checks++; if (bubble_cnt_o !== m_bubble[NW-1:0]) begin
            errors++; $display("FAIL bubble_cnt got %0d exp %0d", bubble_cnt_o, m_bubble[NW-1:0]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        drive(1'b1, rnd_data(), 8'h91, 1'b0, 1'b0);
        drive(1'b1, rnd_data(), 8'h92, 1'b0, 1'b0);
        #3 rst_ni = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || ctrl_o !== 8'h00) begin
            errors++; $display("FAIL async_reset got v=%0b r=%0b c=%h exp 0/1/00", valid_o, ready_o, ctrl_o);
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        q.delete(); m_stall = 0; m_bubble = 0;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL post_reset got v=%0b r=%0b exp 0/1", valid_o, ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_random();
`ifdef PIP_REG_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
